// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits MSB first, even parity, stop bit.
// Each bit is held for BIT_DURATION cycles of clk_3125.
module uart_tx #(
  parameter int unsigned BIT_DURATION = 14
) (
  input  logic       clk_3125,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned FRAME_BITS  = 11;
  localparam int unsigned DATA_BITS_N = FRAME_BITS - 3;
  localparam int unsigned CNT_W       = (BIT_DURATION > 1) ? $clog2(BIT_DURATION) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_DURATION - 1);
  localparam logic [2:0]       IDX_FIRST = 3'(DATA_BITS_N - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    PARITY_BIT,
    STOP_BIT
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       idx, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             tx_d, busy_d, done_d;
  logic             bit_end;

  assign bit_end = (cnt == CNT_LAST);

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk_3125) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      idx     <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx      <= tx_d;
      tx_busy <= busy_d;
      tx_done <= done_d;
    end
  end

  // Next-state and next-output logic; the bit counter wraps at each bit boundary.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx;
    busy_d  = tx_busy;
    done_d  = 1'b0;

    if (state != IDLE) begin
      cnt_d = bit_end ? '0 : cnt + CNT_W'(1);
    end

    case (state)
      IDLE: begin
        cnt_d = '0;
        if (tx_start) begin
          shift_d = tx_data;
          par_d   = ^tx_data;
          idx_d   = IDX_FIRST;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START_BIT;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          tx_d    = shift_q[7];
          shift_d = {shift_q[6:0], 1'b0};
          idx_d   = IDX_FIRST;
          state_d = DATA_BITS;
        end
      end
      DATA_BITS: begin
        if (bit_end) begin
          if (idx == 3'd0) begin
            tx_d    = par_q;
            state_d = PARITY_BIT;
          end else begin
            tx_d    = shift_q[7];
            shift_d = {shift_q[6:0], 1'b0};
            idx_d   = idx - 3'd1;
          end
        end
      end
      PARITY_BIT: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = STOP_BIT;
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues hand-computed frames, a line
// monitor decodes what appears on tx and compares against the queue.
module tb_uart_tx;

  localparam int unsigned BD        = 14;
  localparam int unsigned FRAME_CYC = 11 * BD;

  logic       clk_3125 = 1'b0;
  logic       rst      = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx, tx_busy, tx_done;

  uart_tx #(.BIT_DURATION(BD)) dut (
    .clk_3125 (clk_3125),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk_3125 = ~clk_3125;

  // data, expected parity, expected line bits (start first, stop last)
  typedef struct packed {
    logic [7:0]  data;
    logic        par;
    logic [10:0] frame;
  } vec_t;

  localparam vec_t V_A5 = '{8'hA5, 1'b0, 11'b0_1010_0101_0_1};
  localparam vec_t V_07 = '{8'h07, 1'b1, 11'b0_0000_0111_1_1};
  localparam vec_t V_00 = '{8'h00, 1'b0, 11'b0_0000_0000_0_1};
  localparam vec_t V_FF = '{8'hFF, 1'b0, 11'b0_1111_1111_0_1};
  localparam vec_t V_3C = '{8'h3C, 1'b0, 11'b0_0011_1100_0_1};
  localparam vec_t V_C3 = '{8'hC3, 1'b0, 11'b0_1100_0011_0_1};
  localparam vec_t V_5A = '{8'h5A, 1'b0, 11'b0_0101_1010_0_1};
  localparam vec_t V_69 = '{8'h69, 1'b0, 11'b0_0110_1001_0_1};

  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   n_done = 0;
  int   n_frames_exp = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic expect_frame(input vec_t v);
    exp_q.push_back(v);
    n_frames_exp++;
  endtask

  // Line monitor: acts as the receiver, sampling every cycle of every bit.
  logic        cap = 1'b0;
  int          pos = 0;
  logic [10:0] bits;
  logic        width_ok, busy_ok;
  logic        chk_clear = 1'b0;
  vec_t        e;

  always @(negedge clk_3125) begin
    if (tx_done === 1'b1) n_done++;
    if (chk_clear) begin
      check("done_one_cycle", {31'd0, tx_done}, 32'd0);
      chk_clear = 1'b0;
    end
    if (rst) begin
      cap = 1'b0;
    end else if (cap) begin
      if (pos < FRAME_CYC) begin
        if (pos % BD == 0) bits = {bits[9:0], tx};
        else if (tx !== bits[0]) width_ok = 1'b0;
        if (!(tx_busy === 1'b1 && tx_done === 1'b0)) busy_ok = 1'b0;
        pos++;
      end else begin
        check("end_tx_busy_done", {29'd0, tx, tx_busy, tx_done}, 32'b101);
        chk_clear = 1'b1;
        cap = 1'b0;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_frame: got bits %b expected none", bits);
        end else begin
          e = exp_q.pop_front();
          check("frame_bits", {21'd0, bits}, {21'd0, e.frame});
          check("bit_width", {31'd0, width_ok}, 32'd1);
          check("busy_span", {31'd0, busy_ok}, 32'd1);
          check("rx_msg", {24'd0, bits[9:2]}, {24'd0, e.data});
          check("rx_parity", {31'd0, bits[1]}, {31'd0, e.par});
          check("rx_parity_err", {31'd0, bits[1] ^ (^bits[9:2])}, 32'd0);
        end
      end
    end else if (tx === 1'b0) begin
      cap      = 1'b1;
      pos      = 1;
      bits     = {10'd0, tx};
      width_ok = 1'b1;
      busy_ok  = (tx_busy === 1'b1 && tx_done === 1'b0);
    end
  end

  task automatic send(input logic [7:0] d);
    @(posedge clk_3125);
    #1;
    tx_start = 1'b1;
    tx_data  = d;
    @(posedge clk_3125);
    #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk_3125);
      if (tx_done === 1'b1) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   d0;
    vec_t trio[3];
    trio[0] = V_07;
    trio[1] = V_00;
    trio[2] = V_FF;

    // reset then idle
    repeat (3) @(posedge clk_3125);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_3125);
      check("idle", {29'd0, tx, tx_busy, tx_done}, 32'b100);
    end

    // single pulsed frame
    expect_frame(V_A5);
    send(8'hA5);
    wait_done("a5_done", 200);
    repeat (3) @(negedge clk_3125);

    // receiver-view frames
    for (int k = 0; k < 3; k++) begin
      expect_frame(trio[k]);
      send(trio[k].data);
      wait_done("rx_done", 200);
      repeat (3) @(negedge clk_3125);
    end

    // back-to-back with held tx_start; data changes mid-frame
    expect_frame(V_3C);
    expect_frame(V_C3);
    @(posedge clk_3125);
    #1;
    tx_start = 1'b1;
    tx_data  = 8'h3C;
    repeat (30) @(posedge clk_3125);
    #1;
    tx_data = 8'hC3;
    wait_done("b2b_first_done", 200);
    @(negedge clk_3125);
    check("b2b_restart", {30'd0, tx, tx_busy}, 32'b01);
    tx_start = 1'b0;
    wait_done("b2b_second_done", 200);
    repeat (3) @(negedge clk_3125);

    // tx_start during a frame is ignored
    expect_frame(V_5A);
    send(8'h5A);
    d0 = n_done;
    repeat (19) @(posedge clk_3125);
    #1;
    tx_start = 1'b1;
    tx_data  = 8'hFF;
    @(posedge clk_3125);
    #1;
    tx_start = 1'b0;
    repeat (320) @(negedge clk_3125);
    check("ignored_start_dones", 32'(n_done - d0), 32'd1);
    check("ignored_start_idle", {31'd0, tx_busy}, 32'd0);

    // reset in the middle of a data bit
    send(8'h96);
    repeat (59) @(posedge clk_3125);
    #1;
    rst = 1'b1;
    d0  = n_done;
    @(posedge clk_3125);
    @(negedge clk_3125);
    check("rst_midframe", {29'd0, tx, tx_busy, tx_done}, 32'b100);
    @(posedge clk_3125);
    #1;
    rst = 1'b0;
    repeat (200) @(negedge clk_3125);
    check("rst_no_done", 32'(n_done - d0), 32'd0);

    // clean frame after the aborted one
    expect_frame(V_69);
    send(8'h69);
    wait_done("post_rst_done", 200);
    repeat (3) @(negedge clk_3125);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(n_done), 32'(n_frames_exp));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
